// File: rtl/booth8_pkg.sv
// Shared constants and state type for the radix-8 Booth partial-product datapath.
package booth8_pkg;

    localparam int unsigned PP_W      = 35;
    localparam int unsigned PROD_W    = 64;
    localparam int unsigned NUM_PP    = 11;
    localparam int unsigned GRP_SHIFT = 3;
    localparam int unsigned IDX_W     = 4;

    // Group index of the final partial product; reaching it forces completion.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PP - 1);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_e;

endpackage

// File: rtl/booth8_pp_accum_if.sv
// Partial-product input stream and product output handshake of the accumulator.
interface booth8_pp_accum_if;
    import booth8_pkg::*;

    logic              pp_valid;
    logic              pp_ready;
    logic [PP_W-1:0]   pp_data;
    logic              pp_last;
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] product;
    logic              err_len;

    // Producer of partial products and consumer of the product.
    modport master (
        output pp_valid, pp_data, pp_last, prod_ready,
        input  pp_ready, prod_valid, product, err_len
    );

    // The accumulator itself.
    modport slave (
        input  pp_valid, pp_data, pp_last, prod_ready,
        output pp_ready, prod_valid, product, err_len
    );

endinterface

// File: rtl/booth8_pp_align.sv
// Sign-extends one partial product to product width and weights it by 8^idx.
module booth8_pp_align
    import booth8_pkg::*;
(
    input  logic [PP_W-1:0]   pp_data,
    input  logic [IDX_W-1:0]  idx,
    output logic [PROD_W-1:0] aligned
);

    logic [PROD_W-1:0] pp_sext;
    logic [5:0]        shamt;

    // Shift of GRP_SHIFT bits per group; bits pushed past the MSB are dropped.
    always_comb begin
        pp_sext = {{(PROD_W - PP_W){pp_data[PP_W-1]}}, pp_data};
        shamt   = 6'(idx) * 6'(GRP_SHIFT);
        aligned = pp_sext << shamt;
    end

endmodule

// File: rtl/booth8_pp_accum.sv
// Sequential accumulator of radix-8 Booth partial products into a 64-bit product.
module booth8_pp_accum
    import booth8_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    booth8_pp_accum_if.slave   bus
);

    state_e            state_q, state_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PROD_W-1:0] product_q, product_d;
    logic              err_len_q, err_len_d;
    logic [PROD_W-1:0] aligned;
    logic [PROD_W-1:0] sum;

    booth8_pp_align u_align (
        .pp_data (bus.pp_data),
        .idx     (idx_q),
        .aligned (aligned)
    );

    assign sum            = acc_q + aligned;
    assign bus.pp_ready   = (state_q == ACCUM);
    assign bus.prod_valid = (state_q == HOLD);
    assign bus.product    = product_q;
    assign bus.err_len    = err_len_q;

    // Next-state: accumulate beats in ACCUM, hold the result until it is taken.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        product_d = product_q;
        err_len_d = err_len_q;
        case (state_q)
            ACCUM: begin
                if (bus.pp_valid) begin
                    acc_d = sum;
                    idx_d = idx_q + 1'b1;
                    if (bus.pp_last || (idx_q == LAST_IDX)) begin
                        state_d   = HOLD;
                        product_d = sum;
                        err_len_d = (idx_q != LAST_IDX);
                    end
                end
            end
            HOLD: begin
                if (bus.prod_ready) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    idx_d   = '0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State, accumulator and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            idx_q     <= '0;
            product_q <= '0;
            err_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            product_q <= product_d;
            err_len_q <= err_len_d;
        end
    end

endmodule

// File: tb/tb_booth8_pp_accum.sv
// Randomized self-checking bench for booth8_pp_accum against a sum-of-powers-of-8 model.
module tb_booth8_pp_accum;
    import booth8_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    booth8_pp_accum_if bus ();

    booth8_pp_accum dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [PP_W-1:0] pps [NUM_PP];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: product = sum over beats of pp_i * 8^i, wrapping mod 2^64.
    function automatic logic [63:0] model(input int n);
        longint s  = 0;
        longint p8 = 1;
        for (int i = 0; i < n; i++) begin
            s  += longint'($signed(pps[i])) * p8;
            p8 *= 8;
        end
        return s;
    endfunction

    function automatic logic [PP_W-1:0] rand_pp();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[PP_W-1:0];
    endfunction

    // Sends n beats from pps[], then stalls the product and releases it.
    task automatic run_mult(input int n, input bit use_last, input int stall, input bit gaps);
        logic [63:0] exp;
        exp = model(n);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.pp_valid = 1'b0;
                bus.pp_data  = rand_pp();
                @(posedge clk); #1;
            end
            bus.pp_valid = 1'b1;
            bus.pp_data  = pps[i];
            bus.pp_last  = use_last && (i == n - 1);
            check("pp_ready_accum", bus.pp_ready, 1);
            check("prod_valid_accum", bus.prod_valid, 0);
            @(posedge clk); #1;
        end
        bus.pp_valid = 1'b0;
        bus.pp_last  = 1'b0;
        check("prod_valid_done", bus.prod_valid, 1);
        check("product", bus.product, exp);
        check("err_len", bus.err_len, (n != int'(NUM_PP)) ? 1 : 0);
        for (int s = 0; s < stall; s++) begin
            bus.pp_valid = 1'b1;
            bus.pp_last  = $urandom_range(0, 1);
            bus.pp_data  = rand_pp();
            @(posedge clk); #1;
            check("pp_ready_hold", bus.pp_ready, 0);
            check("prod_valid_hold", bus.prod_valid, 1);
            check("product_hold", bus.product, exp);
        end
        // Beat offered in the handshake cycle must be ignored.
        bus.pp_valid   = 1'b1;
        bus.pp_last    = 1'b0;
        bus.pp_data    = rand_pp();
        bus.prod_ready = 1'b1;
        @(posedge clk); #1;
        bus.prod_ready = 1'b0;
        bus.pp_valid   = 1'b0;
        check("prod_valid_released", bus.prod_valid, 0);
        check("pp_ready_released", bus.pp_ready, 1);
        check("product_kept", bus.product, exp);
    endtask

    initial begin
        rst            = 1'b1;
        bus.pp_valid   = 1'b0;
        bus.pp_data    = '0;
        bus.pp_last    = 1'b0;
        bus.prod_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_prod_valid", bus.prod_valid, 0);
        check("rst_pp_ready", bus.pp_ready, 1);
        check("rst_product", bus.product, 0);
        check("rst_err_len", bus.err_len, 0);

        // Small multiply: -9 + 3*8 = 15.
        foreach (pps[i]) pps[i] = '0;
        pps[0] = 35'h7_FFFF_FFF7;
        pps[1] = 35'd3;
        run_mult(11, 1'b1, 0, 1'b0);
        check("small_const", bus.product, 64'd15);

        // Full-length positive with 5-cycle backpressure.
        foreach (pps[i]) pps[i] = 35'd1;
        run_mult(11, 1'b1, 5, 1'b0);
        check("full_const", bus.product, 64'h0000_0000_4924_9249);

        // Negative top group.
        foreach (pps[i]) pps[i] = '0;
        pps[10] = 35'h7_FFFF_FFFF;
        run_mult(11, 1'b1, 1, 1'b0);
        check("neg_top_const", bus.product, 64'hFFFF_FFFF_C000_0000);

        // Early last.
        foreach (pps[i]) pps[i] = 35'd1;
        run_mult(3, 1'b1, 0, 1'b0);
        check("early_const", bus.product, 64'd73);
        check("early_err", bus.err_len, 1);

        // Forced completion without pp_last.
        run_mult(11, 1'b0, 2, 1'b0);
        check("forced_const", bus.product, 64'h0000_0000_4924_9249);
        check("forced_err", bus.err_len, 0);

        // Reset after 4 accepted beats discards the partial sum.
        foreach (pps[i]) pps[i] = rand_pp();
        for (int i = 0; i < 4; i++) begin
            bus.pp_valid = 1'b1;
            bus.pp_data  = pps[i];
            @(posedge clk); #1;
        end
        bus.pp_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_prod_valid", bus.prod_valid, 0);
        check("midrst_pp_ready", bus.pp_ready, 1);
        check("midrst_product", bus.product, 0);
        foreach (pps[i]) pps[i] = 35'd1;
        run_mult(11, 1'b1, 0, 1'b0);
        check("midrst_full_const", bus.product, 64'h0000_0000_4924_9249);

        // Reset while holding a product.
        foreach (pps[i]) pps[i] = rand_pp();
        for (int i = 0; i < 3; i++) begin
            bus.pp_valid = 1'b1;
            bus.pp_data  = pps[i];
            bus.pp_last  = (i == 2);
            @(posedge clk); #1;
        end
        bus.pp_valid = 1'b0;
        bus.pp_last  = 1'b0;
        check("pre_hold_rst_valid", bus.prod_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("hold_rst_valid", bus.prod_valid, 0);
        check("hold_rst_err", bus.err_len, 0);

        // Random multiplies of random length, gaps and backpressure.
        for (int t = 0; t < 40; t++) begin
            int n;
            n = $urandom_range(1, NUM_PP);
            foreach (pps[i]) pps[i] = rand_pp();
            run_mult(n, (n < int'(NUM_PP)) ? 1'b1 : 1'(($urandom_range(0, 1))),
                     $urandom_range(0, 3), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/booth8_pp_accum.md
Name: booth8_pp_accum

Overview:
- Sequential consumer of radix-8 Booth partial products for the 32x32 multiplier datapath.
- Accepts one 35-bit signed partial product per beat, in group order 0..10.
- Accumulates each beat as pp_i * 8^i into a 64-bit sum and presents the finished product on a valid/ready output.
- Replaces the flat adder tree where area matters; throughput is one beat per cycle.

Parameters:
- PP_W, 35, partial-product width (mcand width + 3), two's complement.
- PROD_W, 64, product/accumulator width.
- NUM_PP, 11, partial products per multiply.
- GRP_SHIFT, 3, bit shift per group index (radix 8).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pp_valid  in  1  partial-product beat valid.
- pp_ready  out  1  block can accept a beat.
- pp_data  in  PP_W  signed partial product for the current group.
- pp_last  in  1  marks the final beat of a multiply.
- prod_valid  out  1  product available.
- prod_ready  in  1  downstream accepts product.
- product  out  PROD_W  accumulated signed product.
- err_len  out  1  qualifies product: beat count at completion != NUM_PP.

Behaviour:
- States: ACCUM (pp_ready=1, prod_valid=0) and HOLD (pp_ready=0, prod_valid=1).
- Reset values: state=ACCUM, acc=0, idx=0, product=0, prod_valid=0, err_len=0. pp_ready=1 from the first cycle after reset.
- Beat accept: pp_valid & pp_ready. The beat updates acc <= acc + (sext64(pp_data) << (GRP_SHIFT*idx)), mod 2^64, and idx <= idx+1.
- Overflow: the 64-bit sum wraps silently; no flag is raised.
- Completion: an accepted beat completes the multiply if pp_last=1 or idx==NUM_PP-1 (forced). On completion:
  - next state is HOLD;
  - product is registered with the final sum, including the completing beat;
  - err_len <= (idx+1 != NUM_PP).
- Latency: prod_valid rises the cycle after the completing beat. A full multiply takes 11 beat cycles + 1.
- HOLD: product and err_len are held stable; pp_valid is ignored.
- Output handshake: prod_valid & prod_ready returns the block to ACCUM next cycle with acc=0 and idx=0. product keeps its last value; only prod_valid drops.
- A new beat cannot be accepted in the handshake cycle (one bubble per multiply).
- pp_last on a forced-completion beat: no error.
- pp_last on beat k<NUM_PP: normal completion with err_len=1.
- pp_valid with pp_ready=0: no effect.
- rst at any point, including mid-sequence or in HOLD: immediate return to reset values next edge. Partial sums are discarded and prod_valid=0.
- Shift ranges 0..30. Bits shifted beyond bit 63 are dropped.

Decomposition:
- Package booth8_pkg holds:
  - constants PP_W, PROD_W, NUM_PP, GRP_SHIFT, IDX_W=4;
  - the state enum {ACCUM, HOLD}.
- One combinational sub-module, booth8_pp_align: sign-extends pp_data to PROD_W and shifts it left by GRP_SHIFT*idx. It is reused by the future tree variant.
- The FSM, accumulator, and index counter stay in the top module.

Test Plan:
- Small multiply: send pp0=35'h7_FFFF_FFF7 (-9) and pp1=3, then 9 zero beats with last on the 11th -> prod_valid 1 cycle later, product=64'd15, err_len=0.
- Full-length positive: 11 beats of 35'h1 with last on the 11th -> product=64'h0000_0000_4924_9249, err_len=0.
- Negative top group: beats 0..9 = 0, beat 10 = 35'h7_FFFF_FFFF (-1) -> product=64'hFFFF_FFFF_C000_0000.
- Backpressure: hold prod_ready=0 for 5 cycles after completion while driving pp_valid=1 -> pp_ready=0, product unchanged. Release -> next sequence accepted 1 cycle later and starts from acc=0.
- Length errors:
  - Early: 3 beats of 35'h1 with last on the 3rd -> product=64'd73, err_len=1.
  - Forced: 11 beats with pp_last never set -> completes on the 11th, err_len=0.
- Reset mid-sequence: assert rst after 4 accepted beats -> prod_valid=0 and idx=0. The next full sequence from test 2 yields 64'h4924_9249.
